mem_test_initiator: RTL

- Initiator for the single-port valid/ready memory interface. Drives addr/wdata/wr_rd/valid and consumes rdata/ready.
- On a start pulse it writes a seed-derived pattern to every address, then reads each address back and compares.
- Reports pass/fail, error count, first failing address and a handshake timeout.
- Sits between a test controller (or CPU register) and a memory instance; used for bring-up and self-test.

---
 rtl/mem_test_if.sv | 39 +++
 rtl/mem_test_initiator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_test_if.sv
// ============================================================================
// Module      : mem_test_if
// Description : Single-port valid/ready memory bus between the test initiator
//               (master) and the memory under test (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_test_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic                  wr_rd;
    logic                  valid;
    logic [WIDTH-1:0]      rdata;
    logic                  ready;

    modport master (
        output addr,
        output wdata,
        output wr_rd,
        output valid,
        input  rdata,
        input  ready
    );

    modport slave (
        input  addr,
        input  wdata,
        input  wr_rd,
        input  valid,
        output rdata,
        output ready
    );
endinterface

`default_nettype wire

// File: rtl/mem_test_initiator.sv
// ============================================================================
// Module      : mem_test_initiator
// Description : Memory self-test initiator: writes seed+addr to every word,
//               reads it back, reports errors/timeout. Optional inverted
//               write/read passes when MEM_TEST_INV_PASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_test_initiator #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 15
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   start,
    input  wire [WIDTH-1:0]       seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH+1:0] err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  timeout_err,
    mem_test_if.master            mem
);

    localparam int                  c_WAIT_W  = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH+1:0] c_ERR_MAX = '1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LIM = c_WAIT_W'(TIMEOUT - 1);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_WR_REQ   = 4'd1;
    localparam logic [3:0] c_WR_WAIT  = 4'd2;
    localparam logic [3:0] c_RD_REQ   = 4'd3;
    localparam logic [3:0] c_RD_WAIT  = 4'd4;
    localparam logic [3:0] c_FIN      = 4'd5;
`ifdef MEM_TEST_INV_PASS_EN
    localparam logic [3:0] c_IWR_REQ  = 4'd6;
    localparam logic [3:0] c_IWR_WAIT = 4'd7;
    localparam logic [3:0] c_IRD_REQ  = 4'd8;
    localparam logic [3:0] c_IRD_WAIT = 4'd9;
`endif

    logic [3:0]            r_state;
    logic [3:0]            w_state_nxt;
    logic [WIDTH-1:0]      r_seed;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_WAIT_W-1:0]   r_wait;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [ADDR_WIDTH+1:0] r_err;
    logic [ADDR_WIDTH-1:0] r_first;
    logic                  r_tmo;

    logic                  w_valid;
    logic                  w_wr_rd;
    logic                  w_inv;
    logic                  w_wait;
    logic                  w_rd_wait;
    logic                  w_next_pass;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_tmo;
    logic                  w_mismatch;
    logic [WIDTH-1:0]      w_pat;
    logic [WIDTH-1:0]      w_exp;

    assign w_accept   = (r_state == c_IDLE) && start;
    assign w_last     = (r_addr == c_LAST);
    assign w_tmo      = !mem.ready && (r_wait == c_WAIT_LIM);
    assign w_pat      = r_seed + WIDTH'(r_addr);
    assign w_exp      = w_inv ? ~w_pat : w_pat;
    assign w_mismatch = w_rd_wait && mem.ready && (mem.rdata != w_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A wait state either advances on ready, aborts on timeout, or stays put.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (start) w_state_nxt = c_WR_REQ;
            c_WR_REQ:  w_state_nxt = c_WR_WAIT;
            c_WR_WAIT: begin
                if (mem.ready)  w_state_nxt = w_last ? c_RD_REQ : c_WR_REQ;
                else if (w_tmo) w_state_nxt = c_FIN;
            end
            c_RD_REQ:  w_state_nxt = c_RD_WAIT;
            c_RD_WAIT: begin
`ifdef MEM_TEST_INV_PASS_EN
                if (mem.ready)  w_state_nxt = w_last ? c_IWR_REQ : c_RD_REQ;
`else
                if (mem.ready)  w_state_nxt = w_last ? c_FIN : c_RD_REQ;
`endif
                else if (w_tmo) w_state_nxt = c_FIN;
            end
`ifdef MEM_TEST_INV_PASS_EN
            c_IWR_REQ:  w_state_nxt = c_IWR_WAIT;
            c_IWR_WAIT: begin
                if (mem.ready)  w_state_nxt = w_last ? c_IRD_REQ : c_IWR_REQ;
                else if (w_tmo) w_state_nxt = c_FIN;
            end
            c_IRD_REQ:  w_state_nxt = c_IRD_WAIT;
            c_IRD_WAIT: begin
                if (mem.ready)  w_state_nxt = w_last ? c_FIN : c_IRD_REQ;
                else if (w_tmo) w_state_nxt = c_FIN;
            end
`endif
            c_FIN:     w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_valid     = 1'b0;
        w_wr_rd     = 1'b0;
        w_inv       = 1'b0;
        w_wait      = 1'b0;
        w_rd_wait   = 1'b0;
        w_next_pass = 1'b0;
        case (r_state)
            c_WR_REQ:  begin w_valid = 1'b1; w_wr_rd = 1'b1; end
            c_WR_WAIT: begin w_wr_rd = 1'b1; w_wait = 1'b1; w_next_pass = 1'b1; end
            c_RD_REQ:  w_valid = 1'b1;
            c_RD_WAIT: begin
                w_wait    = 1'b1;
                w_rd_wait = 1'b1;
`ifdef MEM_TEST_INV_PASS_EN
                w_next_pass = 1'b1;
`endif
            end
`ifdef MEM_TEST_INV_PASS_EN
            c_IWR_REQ:  begin w_valid = 1'b1; w_wr_rd = 1'b1; w_inv = 1'b1; end
            c_IWR_WAIT: begin
                w_wr_rd = 1'b1; w_wait = 1'b1; w_next_pass = 1'b1; w_inv = 1'b1;
            end
            c_IRD_REQ:  begin w_valid = 1'b1; w_inv = 1'b1; end
            c_IRD_WAIT: begin w_wait = 1'b1; w_rd_wait = 1'b1; w_inv = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Wait counter is held at zero outside wait states, so every wait starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seed  <= '0;
            r_addr  <= '0;
            r_wait  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_first <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_wait <= '0;
            if (w_accept) begin
                r_seed  <= seed;
                r_addr  <= '0;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_pass  <= 1'b0;
                r_err   <= '0;
                r_first <= '0;
                r_tmo   <= 1'b0;
            end
            if (w_wait) begin
                if (mem.ready) begin
                    if (!w_last) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                    end else if (w_next_pass) begin
                        r_addr <= '0;
                    end
                    if (w_mismatch) begin
                        if (r_err != c_ERR_MAX) r_err <= r_err + (ADDR_WIDTH+2)'(1);
                        if (r_err == '0)        r_first <= r_addr;
                    end
                end else if (w_tmo) begin
                    r_tmo <= 1'b1;
                end else begin
                    r_wait <= r_wait + c_WAIT_W'(1);
                end
            end
            if (r_state == c_FIN) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (r_err == '0) && !r_tmo;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_err_addr = r_first;
    assign timeout_err    = r_tmo;

    assign mem.addr  = r_addr;
    assign mem.wdata = w_wr_rd ? w_exp : '0;
    assign mem.wr_rd = w_wr_rd;
    assign mem.valid = w_valid;

endmodule

`default_nettype wire
